// File: rtl/rv32i_encode.sv
// RV32I instruction encoder feeding a 2-entry output FIFO with an error counter.
// Define RV32M_EN to also encode the M-extension selectors 48-55.
module rv32i_encode (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [5:0]  INST_SEL,
    input  logic [4:0]  RD_NUM,
    input  logic [4:0]  RS1_NUM,
    input  logic [4:0]  RS2_NUM,
    input  logic [31:0] IMM,
    output logic        INST_VALID,
    input  logic        INST_READY,
    output logic [31:0] INST_CODE,
    output logic        INST_ERR,
    output logic [7:0]  ERR_CNT
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;

    function automatic logic [2:0] sel_funct3(input logic [5:0] sel);
        case (sel)
            6'd5,  6'd11, 6'd16, 6'd24, 6'd29, 6'd42:        return 3'b001;
            6'd12, 6'd17, 6'd19, 6'd30, 6'd43:               return 3'b010;
            6'd20, 6'd31, 6'd44:                             return 3'b011;
            6'd6,  6'd13, 6'd21, 6'd32:                      return 3'b100;
            6'd7,  6'd14, 6'd25, 6'd26, 6'd33, 6'd34, 6'd45: return 3'b101;
            6'd8,  6'd22, 6'd35, 6'd46:                      return 3'b110;
            6'd9,  6'd23, 6'd36, 6'd47:                      return 3'b111;
            default:                                         return 3'b000;
        endcase
    endfunction

    logic        i_ok, b_ok, j_ok, u_ok, sh_ok;
    logic [2:0]  f3;
    logic [6:0]  f7_alt;
    logic [31:0] enc_code;
    logic        enc_err;

    // Immediate range checks: each format's value must be the sign extension of its encodable field.
    assign i_ok  = (IMM[31:11] == {21{IMM[11]}});
    assign b_ok  = (IMM[31:12] == {20{IMM[12]}}) && !IMM[0];
    assign j_ok  = (IMM[31:20] == {12{IMM[20]}}) && !IMM[0];
    assign u_ok  = (IMM[11:0] == 12'h000);
    assign sh_ok = (IMM[31:5] == 27'd0);
    assign f3    = sel_funct3(INST_SEL);
    assign f7_alt = (INST_SEL == 6'd26 || INST_SEL == 6'd28 || INST_SEL == 6'd34) ? 7'b0100000 : 7'b0000000;

    always_comb begin
        enc_code = 32'h0000_0000;
        enc_err  = 1'b0;
        case (INST_SEL)
            6'd0: begin
                enc_code = {IMM[31:12], RD_NUM, OP_LUI};
                enc_err  = !u_ok;
            end
            6'd1: begin
                enc_code = {IMM[31:12], RD_NUM, OP_AUIPC};
                enc_err  = !u_ok;
            end
            6'd2: begin
                enc_code = {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD_NUM, OP_JAL};
                enc_err  = !j_ok;
            end
            6'd3: begin
                enc_code = {IMM[11:0], RS1_NUM, 3'b000, RD_NUM, OP_JALR};
                enc_err  = !i_ok;
            end
            6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: begin
                enc_code = {IMM[12], IMM[10:5], RS2_NUM, RS1_NUM, f3, IMM[4:1], IMM[11], OP_BRANCH};
                enc_err  = !b_ok;
            end
            6'd10, 6'd11, 6'd12, 6'd13, 6'd14: begin
                enc_code = {IMM[11:0], RS1_NUM, f3, RD_NUM, OP_LOAD};
                enc_err  = !i_ok;
            end
            6'd15, 6'd16, 6'd17: begin
                enc_code = {IMM[11:5], RS2_NUM, RS1_NUM, f3, IMM[4:0], OP_STORE};
                enc_err  = !i_ok;
            end
            6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23: begin
                enc_code = {IMM[11:0], RS1_NUM, f3, RD_NUM, OP_IMM};
                enc_err  = !i_ok;
            end
            6'd24, 6'd25, 6'd26: begin
                enc_code = {f7_alt, IMM[4:0], RS1_NUM, f3, RD_NUM, OP_IMM};
                enc_err  = !sh_ok;
            end
            6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36: begin
                enc_code = {f7_alt, RS2_NUM, RS1_NUM, f3, RD_NUM, OP_REG};
            end
            6'd37: enc_code = {4'b0000, IMM[7:0], 20'h0000F};
            6'd38: enc_code = 32'h0000_100F;
            6'd39: enc_code = 32'h0000_0073;
            6'd40: enc_code = 32'h0010_0073;
            6'd41: enc_code = 32'h3020_0073;
            // CSR address is an unsigned 12-bit field, so no range check applies.
            6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd47: begin
                enc_code = {IMM[11:0], RS1_NUM, f3, RD_NUM, OP_SYSTEM};
            end
`ifdef RV32M_EN
            6'd48, 6'd49, 6'd50, 6'd51, 6'd52, 6'd53, 6'd54, 6'd55: begin
                enc_code = {7'b0000001, RS2_NUM, RS1_NUM, INST_SEL[2:0], RD_NUM, OP_REG};
            end
`endif
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_code = 32'h0000_0000;
        end
    end

    fifo_state_t state, state_next;
    logic [31:0] head_code, tail_code;
    logic        head_err, tail_err;
    logic        ready_en;
    logic        push, pop;
    logic        load_head, load_tail, shift_tail;

    assign REQ_READY  = ready_en && (state != FULL);
    assign INST_VALID = (state != EMPTY);
    assign push       = REQ_VALID && REQ_READY;
    assign pop        = INST_VALID && INST_READY;
    assign INST_CODE  = INST_VALID ? head_code : 32'h0000_0000;
    assign INST_ERR   = INST_VALID && head_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= EMPTY;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    // A push in FULL cannot happen because REQ_READY is low there.
    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    load_head  = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_next = FULL;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next = ONE;
                    shift_tail = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_code <= 32'h0000_0000;
            head_err  <= 1'b0;
            tail_code <= 32'h0000_0000;
            tail_err  <= 1'b0;
        end else begin
            if (load_head) begin
                head_code <= enc_code;
                head_err  <= enc_err;
            end else if (shift_tail) begin
                head_code <= tail_code;
                head_err  <= tail_err;
            end
            if (load_tail) begin
                tail_code <= enc_code;
                tail_err  <= enc_err;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR_CNT <= 8'd0;
        end else if (push && enc_err && (ERR_CNT != 8'hFF)) begin
            ERR_CNT <= ERR_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_rv32i_encode.sv
// Directed self-checking bench for rv32i_encode; expectations follow RV32RV32M_EN.
module tb_rv32i_encode;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [5:0]  INST_SEL;
    logic [4:0]  RD_NUM, RS1_NUM, RS2_NUM;
    logic [31:0] IMM;
    logic        INST_VALID;
    logic        INST_READY;
    logic [31:0] INST_CODE;
    logic        INST_ERR;
    logic [7:0]  ERR_CNT;

    int checks = 0;
    int fails  = 0;
    int exp_cnt = 0;

    typedef struct packed {
        logic [5:0]  sel;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] code;
        logic        err;
    } vec_t;

    rv32i_encode dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .INST_SEL   (INST_SEL),
        .RD_NUM     (RD_NUM),
        .RS1_NUM    (RS1_NUM),
        .RS2_NUM    (RS2_NUM),
        .IMM        (IMM),
        .INST_VALID (INST_VALID),
        .INST_READY (INST_READY),
        .INST_CODE  (INST_CODE),
        .INST_ERR   (INST_ERR),
        .ERR_CNT    (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_fields(input vec_t v);
        INST_SEL = v.sel;
        RD_NUM   = v.rd;
        RS1_NUM  = v.rs1;
        RS2_NUM  = v.rs2;
        IMM      = v.imm;
    endtask

    // Presents one request and returns 1 time unit after the edge that accepts it.
    task automatic send_request(input vec_t v);
        @(negedge CLK);
        drive_fields(v);
        REQ_VALID = 1'b1;
        for (int w = 0; w < 20 && !REQ_READY; w++) @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b1) begin
            fails++;
            $display("[TB] FAIL req_ready_timeout: got %b expected 1", REQ_READY);
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic pop_word();
        INST_READY = 1'b1;
        @(posedge CLK);
        #1;
        INST_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        REQ_VALID = 1'b0;
        INST_READY = 1'b0;
        drive_fields('0);
        #12;
        checks++;
        if (REQ_READY !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_ready: got %b expected 0", REQ_READY); end
        checks++;
        if (INST_VALID !== 1'b0) begin fails++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", INST_VALID); end
        checks++;
        if (INST_CODE !== 32'h0) begin fails++; $display("[TB] FAIL reset_inst_code: got %h expected 00000000", INST_CODE); end
        checks++;
        if (INST_ERR !== 1'b0) begin fails++; $display("[TB] FAIL reset_inst_err: got %b expected 0", INST_ERR); end
        checks++;
        if (ERR_CNT !== 8'd0) begin fails++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", ERR_CNT); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (REQ_READY !== 1'b1) begin fails++; $display("[TB] FAIL release_req_ready: got %b expected 1", REQ_READY); end
        exp_cnt = 0;
    endtask

    task automatic test_errors();
        vec_t errs [2];
        errs[0] = '{6'd4,  5'd0, 5'd1, 5'd2, 32'd3,    32'h0, 1'b1};
        errs[1] = '{6'd18, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            send_request(errs[i]);
            exp_cnt++;
            checks++;
            if (INST_VALID !== 1'b1) begin fails++; $display("[TB] FAIL err%0d_valid: got %b expected 1", i, INST_VALID); end
            checks++;
            if (INST_CODE !== 32'h0) begin fails++; $display("[TB] FAIL err%0d_code: got %h expected 00000000", i, INST_CODE); end
            checks++;
            if (INST_ERR !== 1'b1) begin fails++; $display("[TB] FAIL err%0d_flag: got %b expected 1", i, INST_ERR); end
            checks++;
            if (ERR_CNT !== 8'(i + 1)) begin fails++; $display("[TB] FAIL err%0d_count: got %0d expected %0d", i, ERR_CNT, i + 1); end
            pop_word();
        end
    endtask

    task automatic test_encode();
        vec_t vecs [21];
        vecs[0]  = '{6'd18, 5'd1, 5'd0,  5'd0, 32'd5,         32'h00500093, 1'b0};
        vecs[1]  = '{6'd27, 5'd3, 5'd1,  5'd2, 32'd0,         32'h002081B3, 1'b0};
        vecs[2]  = '{6'd2,  5'd1, 5'd0,  5'd0, 32'd8,         32'h008000EF, 1'b0};
        vecs[3]  = '{6'd0,  5'd2, 5'd0,  5'd0, 32'h12345000,  32'h12345137, 1'b0};
        vecs[4]  = '{6'd17, 5'd0, 5'd2,  5'd3, 32'd8,         32'h00312423, 1'b0};
        vecs[5]  = '{6'd4,  5'd0, 5'd1,  5'd2, 32'hFFFFFFFC,  32'hFE208EE3, 1'b0};
        vecs[6]  = '{6'd26, 5'd1, 5'd1,  5'd0, 32'd3,         32'h4030D093, 1'b0};
        vecs[7]  = '{6'd39, 5'd5, 5'd3,  5'd0, 32'd0,         32'h00000073, 1'b0};
        vecs[8]  = '{6'd37, 5'd0, 5'd0,  5'd0, 32'h000000FF,  32'h0FF0000F, 1'b0};
        vecs[9]  = '{6'd42, 5'd1, 5'd2,  5'd0, 32'h00000300,  32'h300110F3, 1'b0};
        vecs[10] = '{6'd24, 5'd1, 5'd1,  5'd0, 32'd32,        32'h0,        1'b1};
        vecs[11] = '{6'd60, 5'd1, 5'd1,  5'd1, 32'd0,         32'h0,        1'b1};
        vecs[12] = '{6'd2,  5'd1, 5'd0,  5'd0, 32'h00100000,  32'h0,        1'b1};
        vecs[13] = '{6'd41, 5'd0, 5'd0,  5'd0, 32'd0,         32'h30200073, 1'b0};
        vecs[14] = '{6'd28, 5'd1, 5'd2,  5'd3, 32'd0,         32'h403100B3, 1'b0};
        vecs[15] = '{6'd12, 5'd5, 5'd10, 5'd0, 32'hFFFFFFFC,  32'hFFC52283, 1'b0};
        vecs[16] = '{6'd0,  5'd1, 5'd0,  5'd0, 32'h12345001,  32'h0,        1'b1};
        vecs[17] = '{6'd5,  5'd0, 5'd0,  5'd0, 32'h00000FFE,  32'h7E001FE3, 1'b0};
        vecs[18] = '{6'd7,  5'd0, 5'd0,  5'd0, 32'h00001000,  32'h0,        1'b1};
        vecs[19] = '{6'd2,  5'd0, 5'd0,  5'd0, 32'h000FFFFE,  32'h7FFFF06F, 1'b0};
        vecs[20] = '{6'd18, 5'd1, 5'd0,  5'd0, 32'hFFFFF800,  32'h80000093, 1'b0};
        for (int i = 0; i < 21; i++) begin
            send_request(vecs[i]);
            if (vecs[i].err) exp_cnt++;
            checks++;
            if (INST_VALID !== 1'b1) begin fails++; $display("[TB] FAIL vec%0d_valid: got %b expected 1", i, INST_VALID); end
            checks++;
            if (INST_CODE !== vecs[i].code) begin fails++; $display("[TB] FAIL vec%0d_code: got %h expected %h", i, INST_CODE, vecs[i].code); end
            checks++;
            if (INST_ERR !== vecs[i].err) begin fails++; $display("[TB] FAIL vec%0d_err: got %b expected %b", i, INST_ERR, vecs[i].err); end
            checks++;
            if (ERR_CNT !== 8'(exp_cnt)) begin fails++; $display("[TB] FAIL vec%0d_err_cnt: got %0d expected %0d", i, ERR_CNT, exp_cnt); end
            pop_word();
            checks++;
            if (INST_VALID !== 1'b0) begin fails++; $display("[TB] FAIL vec%0d_drained: got %b expected 0", i, INST_VALID); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t seq [3];
        logic [31:0] got [$];
        int sent;
        logic acc, popd;
        logic [31:0] hd;
        seq[0] = '{6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0};
        seq[1] = '{6'd27, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0};
        seq[2] = '{6'd2,  5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF, 1'b0};
        @(negedge CLK);
        INST_READY = 1'b0;
        drive_fields(seq[0]);
        REQ_VALID = 1'b1;
        sent = 0;
        for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
            if (cyc == 4) INST_READY = 1'b1;
            acc  = REQ_VALID && REQ_READY;
            popd = INST_VALID && INST_READY;
            hd   = INST_CODE;
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (REQ_READY !== 1'b0) begin fails++; $display("[TB] FAIL b2b_full_ready_c%0d: got %b expected 0", cyc, REQ_READY); end
                checks++;
                if (INST_CODE !== seq[0].code) begin fails++; $display("[TB] FAIL b2b_stall_hold_c%0d: got %h expected %h", cyc, INST_CODE, seq[0].code); end
            end
            @(posedge CLK);
            #1;
            if (popd) got.push_back(hd);
            if (acc) begin
                sent++;
                if (sent < 3) drive_fields(seq[sent]);
                else REQ_VALID = 1'b0;
            end
            @(negedge CLK);
        end
        REQ_VALID = 1'b0;
        INST_READY = 1'b0;
        checks++;
        if (got.size() != 3) begin fails++; $display("[TB] FAIL b2b_word_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== seq[i].code) begin fails++; $display("[TB] FAIL b2b_order%0d: got %h expected %h", i, got[i], seq[i].code); end
            end
        end
        checks++;
        if (INST_VALID !== 1'b0) begin fails++; $display("[TB] FAIL b2b_no_duplicate: got %b expected 0", INST_VALID); end
    endtask

    task automatic test_mul();
        vec_t v;
        logic [31:0] exp_code;
        logic exp_err;
`ifdef RV32M_EN
        exp_code = 32'h027302B3;
        exp_err  = 1'b0;
`else
        exp_code = 32'h00000000;
        exp_err  = 1'b1;
`endif
        v = '{6'd48, 5'd5, 5'd6, 5'd7, 32'd0, 32'h0, 1'b0};
        send_request(v);
        if (exp_err) exp_cnt++;
        checks++;
        if (INST_CODE !== exp_code) begin fails++; $display("[TB] FAIL mul_code: got %h expected %h", INST_CODE, exp_code); end
        checks++;
        if (INST_ERR !== exp_err) begin fails++; $display("[TB] FAIL mul_err: got %b expected %b", INST_ERR, exp_err); end
        checks++;
        if (ERR_CNT !== 8'(exp_cnt)) begin fails++; $display("[TB] FAIL mul_err_cnt: got %0d expected %0d", ERR_CNT, exp_cnt); end
        pop_word();
    endtask

    task automatic test_saturate();
        int acc_cnt;
        @(negedge CLK);
        drive_fields('{6'd60, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0, 1'b1});
        REQ_VALID = 1'b1;
        INST_READY = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (REQ_READY) acc_cnt++;
            @(negedge CLK);
        end
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        INST_READY = 1'b0;
        exp_cnt = 255;
        checks++;
        if (acc_cnt != 300) begin fails++; $display("[TB] FAIL stream_rate: got %0d expected 300", acc_cnt); end
        checks++;
        if (ERR_CNT !== 8'd255) begin fails++; $display("[TB] FAIL err_cnt_saturate: got %0d expected 255", ERR_CNT); end
        checks++;
        if (INST_VALID !== 1'b0) begin fails++; $display("[TB] FAIL stream_drained: got %b expected 0", INST_VALID); end
    endtask

    task automatic test_reset_mid();
        vec_t a, b, c;
        a = '{6'd27, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0};
        b = '{6'd2,  5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF, 1'b0};
        c = '{6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0};
        INST_READY = 1'b0;
        send_request(a);
        send_request(b);
        checks++;
        if (REQ_READY !== 1'b0) begin fails++; $display("[TB] FAIL mid_full_ready: got %b expected 0", REQ_READY); end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (INST_VALID !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", INST_VALID); end
        checks++;
        if (ERR_CNT !== 8'd0) begin fails++; $display("[TB] FAIL mid_reset_err_cnt: got %0d expected 0", ERR_CNT); end
        checks++;
        if (REQ_READY !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_ready: got %b expected 0", REQ_READY); end
        checks++;
        if (INST_CODE !== 32'h0) begin fails++; $display("[TB] FAIL mid_reset_code: got %h expected 00000000", INST_CODE); end
        exp_cnt = 0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (REQ_READY !== 1'b1) begin fails++; $display("[TB] FAIL mid_release_ready: got %b expected 1", REQ_READY); end
        @(posedge CLK);
        #1;
        checks++;
        if (INST_VALID !== 1'b0) begin fails++; $display("[TB] FAIL mid_no_stale: got %b expected 0", INST_VALID); end
        send_request(c);
        checks++;
        if (INST_CODE !== c.code) begin fails++; $display("[TB] FAIL mid_fresh_word: got %h expected %h", INST_CODE, c.code); end
        pop_word();
        checks++;
        if (INST_VALID !== 1'b0) begin fails++; $display("[TB] FAIL mid_final_empty: got %b expected 0", INST_VALID); end
    endtask

    initial begin
        test_reset();
        test_errors();
        test_encode();
        test_back_to_back();
        test_mul();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_encode.md
RV32I_ENCODE -- requirements
Module: rv32i_encode

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port RST_N, input, 1, reset; asynchronous assert, active-low.
REQ-003 SHALL have port REQ_VALID, input, 1, request present.
REQ-004 SHALL have port REQ_READY, output, 1, encoder can accept a request.
REQ-005 SHALL have port INST_SEL, input, 6, instruction selector: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4-9 BEQ/BNE/BLT/BGE/BLTU/BGEU, 10-14 LB/LH/LW/LBU/LHU, 15-17 SB/SH/SW, 18-26 ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, 27-36 ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, 37 FENCE, 38 FENCEI, 39 ECALL, 40 EBREAK, 41 MRET, 42-47 CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI, 48-55 MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, 56-63 undefined.
REQ-006 SHALL have ports RD_NUM, RS1_NUM, RS2_NUM, input, 5 each, register numbers; RS1_NUM is zimm for CSR*I.
REQ-007 SHALL have port IMM, input, 32, byte-offset/immediate value; IMM[11:0] is the CSR address for CSR ops; IMM[7:0] is pred/succ for FENCE.
REQ-008 SHALL have port INST_VALID, output, 1, encoded word available.
REQ-009 SHALL have port INST_READY, input, 1, consumer accepts word.
REQ-010 SHALL have port INST_CODE, output, 32, encoded instruction word.
REQ-011 SHALL have port INST_ERR, output, 1, current word is an encode error.
REQ-012 SHALL have port ERR_CNT, output, 8, saturating count of accepted error requests.

Function
REQ-013 SHALL encode with standard RV32 field placement: R {f7,rs2,rs1,f3,rd,op}; I {IMM[11:0],rs1,f3,rd,op}; S/B/U/J standard bit scattering; fields not used by a type are zero.
REQ-014 SHALL encode fixed words: FENCE {4'b0,IMM[7:0],20'h0000F}, FENCEI 32'h0000100F, ECALL 32'h00000073, EBREAK 32'h00100073, MRET 32'h30200073.
REQ-015 SHALL flag error when: I/S IMM not sign-extension of IMM[11:0]; B IMM outside -4096..4094 or IMM[0]=1; J IMM outside -1048576..1048574 or IMM[0]=1; U IMM[11:0]!=0; SLLI/SRLI/SRAI IMM[31:5]!=0; INST_SEL 56-63.
REQ-016 SHALL, on error, enqueue INST_CODE=32'h00000000 with INST_ERR=1; an error never blocks the pipeline.
REQ-017 SHALL buffer accepted words in a 2-entry FIFO (states EMPTY, ONE, FULL); REQ_READY = not FULL.
REQ-018 SHALL accept on REQ_VALID&&REQ_READY and pop on INST_VALID&&INST_READY; INST_VALID = not EMPTY; INST_CODE/INST_ERR show head entry.
REQ-019 SHALL show a word accepted at edge N on INST_VALID after edge N (one-cycle latency) when EMPTY.
REQ-020 SHALL, on simultaneous push and pop in ONE, remain in ONE with the new word at head; sustain 1 word/cycle.
REQ-021 SHALL hold INST_CODE/INST_ERR stable while INST_VALID=1 and INST_READY=0.
REQ-022 SHALL preserve request order; no word dropped or duplicated.
REQ-023 SHALL increment ERR_CNT on each accepted error request, saturating at 255.

Reset
REQ-024 SHALL, while RST_N=0, force FIFO EMPTY, REQ_READY=0, INST_VALID=0, INST_CODE=0, INST_ERR=0, ERR_CNT=0.
REQ-025 SHALL discard buffered words on reset mid-operation; REQ_READY=1 from first edge after RST_N deasserts.

Configuration
REQ-026 SHALL, with RV32M_EN defined, encode selectors 48-55 as R-type op 0110011, f7 0000001, f3 0-7.
REQ-027 SHALL, without RV32M_EN, treat selectors 48-55 as errors (REQ-016) and omit M-extension logic.

Verification
REQ-028 SHALL check ADDI rd=1 rs1=0 IMM=5 -> INST_CODE 32'h00500093, INST_ERR=0, one cycle after accept.
REQ-029 SHALL check ADD rd=3 rs1=1 rs2=2 -> 32'h002081B3; JAL rd=1 IMM=8 -> 32'h008000EF.
REQ-030 SHALL check BEQ IMM=3 and ADDI IMM=2048 -> 32'h00000000, INST_ERR=1, ERR_CNT increments to 1 then 2.
REQ-031 SHALL check INST_READY=0 with three back-to-back requests -> REQ_READY low after two accepts; release -> three words out in order.
REQ-032 SHALL check MUL rd=5 rs1=6 rs2=7 -> 32'h027302B3 with RV32M_EN; INST_ERR=1 without.
REQ-033 SHALL check RST_N low while FULL -> INST_VALID=0 immediately, ERR_CNT=0, no stale word after release.
